bram_arbiter: RTL and testbench



---
 rtl/bram_arbiter_pkg.sv | 38 +++
 rtl/bram_arbiter_rr.sv | 36 +++
 rtl/brams.sv | 35 +++
 rtl/bram_arbiter.sv | 150 +++++++++++++++
 tb/tb_bram_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared types and helpers for the block-RAM arbiter.
package bram_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Fixed read latency from grant to rvalid (address reg + output reg).
  localparam int RD_LAT = 2;

  // Widest requester vector the grant helper handles.
  localparam int MAX_REQ = 8;
  localparam int SEL_W   = 3;

  // Round-robin search starting at ptr, wrapping modulo n (n need not be a
  // power of two). Returns a one-hot grant, or zero when nothing requests.
  function automatic logic [MAX_REQ-1:0] onehot_rr(input logic [MAX_REQ-1:0] req,
                                                   input int ptr,
                                                   input int n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    logic [SEL_W-1:0]   sel;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        sel = SEL_W'((ptr + k) % n);
        if (!found && req[sel]) begin
          g[sel] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/bram_arbiter_rr.sv
// Round-robin grant generator with a modulo-N priority pointer.
module rr_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] take,
  output logic [N_REQ-1:0] gnt
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [MAX_REQ-1:0] gnt_full;

  assign gnt_full = onehot_rr(MAX_REQ'(req), int'(ptr), N_REQ);
  assign gnt      = gnt_full[N_REQ-1:0];

  // The requester just served moves to lowest priority.
  always_comb begin
    ptr_next = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (take[i]) ptr_next = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) ptr <= '0;
    else         ptr <= ptr_next;
  end

endmodule

// File: rtl/brams.sv
// Single-port block RAM with registered address and registered output.
// The asynchronous clear only touches the address and output registers.
module brams #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 8
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             en,
  input  logic             we,
  input  logic [ADDR_-1:0] addr,
  input  logic [DATA_-1:0] din,
  output logic [DATA_-1:0] q
);

  logic [DATA_-1:0] mem [2**ADDR_];
  logic [ADDR_-1:0] addr_reg;

  // Array write port; kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= din;
  end

  // Address register loads on every access; output register reads through it.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      addr_reg <= '0;
      q        <= '0;
    end else begin
      if (en) addr_reg <= addr;
      q <= mem[addr_reg];
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port block RAM among N_REQ requesters with round-robin
// arbitration, optional bus locking and a fixed-latency read return path.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_    = 8,
  parameter int DATA_    = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic                   clk,
  input  logic                   aclr_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ*ADDR_-1:0] addr,
  input  logic [N_REQ*DATA_-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rvalid,
  output logic [DATA_-1:0]       rdata,
  output logic                   busy
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_e       state, state_next;
  logic [ID_W-1:0]  owner, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic [N_REQ-1:0] rr_gnt, take;
  logic [ID_W-1:0]  gidx;
  logic             ram_en, ram_we, rd_issue;
  logic [ADDR_-1:0] ram_addr;
  logic [DATA_-1:0] ram_din;
  logic             v1, v2;
  logic [ID_W-1:0]  id1, id2;

  logic [ADDR_-1:0] addr_s [N_REQ];
  logic [DATA_-1:0] din_s  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign addr_s[gi] = addr[gi*ADDR_ +: ADDR_];
      assign din_s[gi]  = din[gi*DATA_ +: DATA_];
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk    (clk),
    .aclr_n (aclr_n),
    .req    (req),
    .take   (take),
    .gnt    (rr_gnt)
  );

  // Final grant: locked owner overrides round-robin; nothing granted in reset.
  always_comb begin
    gnt = '0;
    if (state == LOCKED) begin
      if (req[owner]) gnt[owner] = 1'b1;
    end else begin
      gnt = rr_gnt;
    end
    if (!aclr_n) gnt = '0;
  end

  assign take = req & gnt;

  // Index of the accepted access and the RAM port mux.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (take[i]) gidx = ID_W'(i);
    end
    ram_en   = |take;
    ram_we   = |(take & we);
    ram_addr = addr_s[gidx];
    ram_din  = din_s[gidx];
    rd_issue = ram_en && !ram_we;
  end

  assign cnt_inc = (cnt == CNT_W'(MAX_LOCK)) ? cnt : cnt + 1'b1;

  // Lock FSM: enter on a locked grant, leave on release, idle or budget spent.
  always_comb begin
    state_next = state;
    owner_next = owner;
    cnt_next   = cnt;
    case (state)
      ARB: begin
        if (ram_en && lock[gidx]) begin
          state_next = LOCKED;
          owner_next = gidx;
          cnt_next   = CNT_W'(1);
        end
      end
      LOCKED: begin
        cnt_next = cnt_inc;
        if (!lock[owner] || !req[owner] || cnt_inc == CNT_W'(MAX_LOCK)) begin
          state_next = ARB;
          cnt_next   = '0;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state <= ARB;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
      cnt   <= cnt_next;
    end
  end

  // Read-tracking pipeline mirroring the RAM address and output registers.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      id1  <= '0;
      id2  <= '0;
      busy <= 1'b0;
    end else begin
      v1   <= rd_issue;
      id1  <= gidx;
      v2   <= v1;
      id2  <= id1;
      busy <= rd_issue | v1;
    end
  end

  assign rvalid = v2 ? (N_REQ'(1) << id2) : '0;

  brams #(.ADDR_(ADDR_), .DATA_(DATA_)) u_ram (
    .clk  (clk),
    .aclr (~aclr_n),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .q    (rdata)
  );

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: reset, write, read latency, round-robin,
// lock budget, reset during a read, and pointer wrap with three requesters.
module tb_bram_arbiter;
  import bram_arbiter_pkg::*;

  logic        clk;
  logic        aclr_n;
  logic [1:0]  req, lock, we, gnt, rvalid;
  logic [15:0] addr, din;
  logic [7:0]  rdata;
  logic        busy;

  logic [2:0]  req3, lock3, we3, gnt3, rvalid3;
  logic [23:0] addr3, din3;
  logic [7:0]  rdata3;
  logic        busy3;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_g [0:7];

  bram_arbiter #(.N_REQ(2), .ADDR_(8), .DATA_(8), .MAX_LOCK(16)) dut (
    .clk(clk), .aclr_n(aclr_n), .req(req), .lock(lock), .we(we),
    .addr(addr), .din(din), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy)
  );

  bram_arbiter #(.N_REQ(3), .ADDR_(8), .DATA_(8), .MAX_LOCK(16)) dut3 (
    .clk(clk), .aclr_n(aclr_n), .req(req3), .lock(lock3), .we(we3),
    .addr(addr3), .din(din3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .busy(busy3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Drive point: just after the falling edge, well clear of the rising edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    aclr_n = 1'b0;
    req = 2'b11; lock = '0; we = '0; addr = '0; din = '0;
    req3 = '0; lock3 = '0; we3 = '0; addr3 = '0; din3 = '0;

    // Reset held for three cycles with requests pending.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'h0);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end
    @(negedge clk);
    aclr_n = 1'b1;
    req = '0;

    // Requester 0 writes 0x10 <= 0xA5 (pointer -> 1).
    cyc();
    req = 2'b01; we = 2'b01; addr = 16'h0010; din = 16'h00A5;
    #1 check("wr0_gnt", 32'(gnt), 32'h1);
    // Requester 1 writes 0x20 <= 0x3C (pointer -> 0).
    cyc();
    req = 2'b10; we = 2'b10; addr = 16'h2000; din = 16'h3C00;
    #1 check("wr1_gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      req = '0; we = '0;
      #1 check("wr_no_rvalid", 32'(rvalid), 32'h0);
      check("wr_no_busy", 32'(busy), 32'h0);
    end

    // Latency: requester 1 reads 0x10 in cycle T.
    cyc();
    req = 2'b10; addr = 16'h1000;
    #1 check("lat_gnt_T", 32'(gnt), 32'h2);
    cyc();
    req = '0;
    #1 check("lat_busy_T1", 32'(busy), 32'h1);
    check("lat_rvalid_T1", 32'(rvalid), 32'h0);
    cyc();
    check("lat_rvalid_T2", 32'(rvalid), 32'h2);
    check("lat_rdata_T2", 32'(rdata), 32'hA5);
    check("lat_busy_T2", 32'(busy), 32'h1);
    cyc();
    check("lat_rvalid_T3", 32'(rvalid), 32'h0);
    check("lat_busy_T3", 32'(busy), 32'h0);

    // Round-robin: both read continuously for six cycles.
    addr = 16'h2010;
    for (int k = 0; k < 8; k++) begin
      cyc();
      req = (k < 6) ? 2'b11 : 2'b00;
      exp_g[k] = (k < 6) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      #1 check($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(exp_g[k]));
      if (k >= 2) begin
        check($sformatf("rr_rvalid_%0d", k), 32'(rvalid), 32'(exp_g[k-2]));
        check($sformatf("rr_rdata_%0d", k), 32'(rdata), (exp_g[k-2] == 2'b01) ? 32'hA5 : 32'h3C);
      end
    end
    cyc();
    cyc();

    // Lock: requester 0 locks while requester 1 also requests.
    for (int k = 0; k < 17; k++) begin
      cyc();
      req = 2'b11; lock = 2'b01;
      #1 check($sformatf("lock_gnt_%0d", k), 32'(gnt), (k < 16) ? 32'h1 : 32'h2);
    end
    cyc();
    req = '0; lock = '0;
    cyc();
    cyc();
    cyc();

    // Reset during a locked read from requester 1.
    req = 2'b10; lock = 2'b10; addr = 16'h1000;
    #1 check("mid_gnt_T", 32'(gnt), 32'h2);
    cyc();
    req = '0; lock = '0;
    aclr_n = 1'b0;
    #1 check("mid_gnt_rst", 32'(gnt), 32'h0);
    cyc();
    check("mid_rvalid_T2", 32'(rvalid), 32'h0);
    check("mid_rdata_T2", 32'(rdata), 32'h0);
    check("mid_busy_T2", 32'(busy), 32'h0);
    aclr_n = 1'b1;
    cyc();
    req = 2'b11;
    #1 check("mid_gnt_after", 32'(gnt), 32'h1);
    check("mid_rvalid_after", 32'(rvalid), 32'h0);
    cyc();
    req = '0;
    cyc();
    cyc();

    // Pointer wrap with three requesters.
    cyc();
    req3 = 3'b100;
    #1 check("wrap_gnt2", 32'(gnt3), 32'h4);
    cyc();
    req3 = 3'b101;
    #1 check("wrap_gnt0", 32'(gnt3), 32'h1);
    cyc();
    req3 = 3'b101;
    #1 check("wrap_gnt2b", 32'(gnt3), 32'h4);
    cyc();
    req3 = '0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
